// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI3 bridge: FSM states, size codes, AXI tie-offs.
// Also hosts the kseg address map used when SRAM_AXI_BRIDGE_KSEG_MAP_EN is defined.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } bridge_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE  = 3'd0;

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) alias the low 512 MB of physical space.
    function automatic logic [31:0] kseg_map(input logic [31:0] addr);
        return (addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
    endfunction

endpackage

// File: rtl/sram_axi_strb_gen.sv
// Byte-lane write strobe generator from access size and low address bits.
module sram_axi_strb_gen
    import sram_axi_bridge_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    // Size 3 is illegal on the core side and is treated as a full word.
    always_comb begin
        wstrb_o = 4'b1111;
        case (size_i)
            SZ_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
            SZ_HALF: wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            default: wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the core's inst/data sram-like ports onto one AXI3 master, one transaction at a time.
// Optional build macro SRAM_AXI_BRIDGE_KSEG_MAP_EN strips addr[31:29] for kseg0/kseg1 addresses.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int   ID_W     = 4,
    parameter logic DATA_PRI = 1'b1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic [31:0]     inst_rdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,

    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic [31:0]     data_rdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,

    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    bridge_state_e state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [31:0]   inst_rdata_q, inst_rdata_d;
    logic [31:0]   data_rdata_q, data_rdata_d;

    logic          sel_data;
    logic          aw_fire;
    logic          w_fire;
    logic [31:0]   axi_addr;

    // Responses carry no information this single-outstanding bridge acts on.
    logic          unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    assign sel_data = data_req && (!inst_req || DATA_PRI);
    assign aw_fire  = awvalid && awready;
    assign w_fire   = wvalid && wready;

`ifdef SRAM_AXI_BRIDGE_KSEG_MAP_EN
    assign axi_addr = kseg_map(addr_q);
`else
    assign axi_addr = addr_q;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        case (state_q)
            // addr_ok is combinational so the core sees acceptance in its request cycle.
            IDLE: begin
                if ((inst_req || data_req) && !rst) begin
                    owner_d      = sel_data;
                    wr_d         = sel_data ? data_wr    : inst_wr;
                    size_d       = sel_data ? data_size  : inst_size;
                    addr_d       = sel_data ? data_addr  : inst_addr;
                    wdata_d      = sel_data ? data_wdata : inst_wdata;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    data_addr_ok = sel_data;
                    inst_addr_ok = !sel_data;
                    state_d      = (sel_data ? data_wr : inst_wr) ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (owner_q) data_rdata_d = rdata;
                    else         inst_rdata_d = rdata;
                    state_d = DONE;
                end
            end
            // AW and W complete independently; move on once both have handshaken.
            WR_REQ: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_d = DONE;
            end
            DONE: begin
                data_data_ok = owner_q;
                inst_data_ok = !owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    sram_axi_strb_gen u_strb_gen (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wstrb_o   (wstrb)
    );

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

    assign arid    = '0;
    assign araddr  = axi_addr;
    assign arsize  = {1'b0, size_q};
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NONE;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    assign awid    = '0;
    assign awaddr  = axi_addr;
    assign awsize  = {1'b0, size_q};
    assign awlen   = AXI_LEN_SINGLE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;

    assign wid   = '0;
    assign wdata = wdata_q;
    assign wlast = wvalid;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: directed scenarios then randomized traffic against a
// transaction-level reference model; honours SRAM_AXI_BRIDGE_KSEG_MAP_EN for expected addresses.
module tb_sram_axi_bridge;

    localparam int   ID_W     = 4;
    localparam logic DATA_PRI = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    logic clk, rst;
    logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0] inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0] data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0] arlen, arcache, awlen, awcache, wstrb;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] expInstRdata, expDataRdata;

    sram_axi_bridge #(.ID_W(ID_W), .DATA_PRI(DATA_PRI)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // Physical address the bus should see for a core address.
    function automatic logic [31:0] modelAddr(input logic [31:0] a);
`ifdef SRAM_AXI_BRIDGE_KSEG_MAP_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    function automatic logic [3:0] modelStrb(input logic [1:0] size, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (size == 2'd0) return 4'(32'd1 << lane);
        if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic req_t randomReq();
        req_t r;
        r.wr    = 1'($urandom % 2);
        r.size  = 2'($urandom % 4);
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.rdata = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one arbitration round: the model picks the winner, the bench plays the AXI slave
    // with the given handshake delays and checks every channel plus completion to the winner.
    task automatic applyStimulus(input req_t ir, input bit iOn, input req_t dr, input bit dOn,
                                 input int arDly, input int rDly, input int awDly,
                                 input int wDly, input int bDly);
        bit   winData;
        req_t w;
        bit   awDone, wDone;
        int   cyc;
        winData = dOn && (!iOn || DATA_PRI);
        w = winData ? dr : ir;
        inst_req = iOn; inst_wr = ir.wr; inst_size = ir.size; inst_addr = ir.addr; inst_wdata = ir.wdata;
        data_req = dOn; data_wr = dr.wr; data_size = dr.size; data_addr = dr.addr; data_wdata = dr.wdata;
        #1;
        checkOutput("inst_addr_ok_grant", 32'(inst_addr_ok), 32'(iOn && !winData));
        checkOutput("data_addr_ok_grant", 32'(data_addr_ok), 32'(winData));
        @(posedge clk); #1;
        if (winData) data_req = 1'b0; else inst_req = 1'b0;
        #1;
        checkOutput("addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        if (!w.wr) begin
            for (int c = 0; c <= arDly; c++) begin
                arready = (c == arDly);
                #1;
                checkOutput("arvalid", 32'(arvalid), 32'd1);
                checkOutput("rready_in_ar", 32'(rready), 32'd0);
                if (arready) begin
                    checkOutput("araddr", araddr, modelAddr(w.addr));
                    checkOutput("arsize", 32'(arsize), 32'(w.size));
                end
                @(posedge clk); #1;
            end
            arready = 1'b0;
            for (int c = 0; c <= rDly; c++) begin
                rvalid = (c == rDly);
                rdata  = rvalid ? w.rdata : $urandom;
                rresp  = 2'($urandom);
                rlast  = 1'($urandom);
                #1;
                checkOutput("rready", 32'(rready), 32'd1);
                checkOutput("arvalid_in_r", 32'(arvalid), 32'd0);
                checkOutput("data_ok_early_r", 32'({inst_data_ok, data_data_ok}), 32'd0);
                @(posedge clk); #1;
            end
            rvalid = 1'b0;
            if (winData) expDataRdata = w.rdata; else expInstRdata = w.rdata;
        end else begin
            awDone = 1'b0; wDone = 1'b0; cyc = 0;
            while (!(awDone && wDone)) begin
                if (cyc > 40) begin
                    compared++; mismatched++;
                    $error("[TB] FAIL write_handshake_timeout: observed %0d cycles required <= 40", cyc);
                    break;
                end
                awready = (cyc >= awDly) && !awDone;
                wready  = (cyc >= wDly) && !wDone;
                #1;
                checkOutput("awvalid", 32'(awvalid), 32'(!awDone));
                checkOutput("wvalid", 32'(wvalid), 32'(!wDone));
                if (!wDone) begin
                    checkOutput("wlast", 32'(wlast), 32'd1);
                    checkOutput("wdata", wdata, w.wdata);
                    checkOutput("wstrb", 32'(wstrb), 32'(modelStrb(w.size, w.addr)));
                end
                if (!awDone) begin
                    checkOutput("awaddr", awaddr, modelAddr(w.addr));
                    checkOutput("awsize", 32'(awsize), 32'(w.size));
                end
                checkOutput("data_ok_early_w", 32'({inst_data_ok, data_data_ok, bready}), 32'd0);
                @(posedge clk); #1;
                if (awready) awDone = 1'b1;
                if (wready)  wDone  = 1'b1;
                cyc++;
            end
            awready = 1'b0; wready = 1'b0;
            for (int c = 0; c <= bDly; c++) begin
                bvalid = (c == bDly);
                bresp  = 2'($urandom);
                #1;
                checkOutput("bready", 32'(bready), 32'd1);
                checkOutput("aw_w_idle_in_b", 32'({awvalid, wvalid}), 32'd0);
                checkOutput("data_ok_early_b", 32'({inst_data_ok, data_data_ok}), 32'd0);
                @(posedge clk); #1;
            end
            bvalid = 1'b0;
        end
        #1;
        checkOutput("inst_data_ok_done", 32'(inst_data_ok), 32'(!winData));
        checkOutput("data_data_ok_done", 32'(data_data_ok), 32'(winData));
        checkOutput("inst_rdata", inst_rdata, expInstRdata);
        checkOutput("data_rdata", data_rdata, expDataRdata);
        checkOutput("addr_ok_in_done", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        @(posedge clk); #1;
        checkOutput("data_ok_one_cycle", 32'({inst_data_ok, data_data_ok}), 32'd0);
    endtask

    initial begin
        req_t ir, dr;
        bit   iOn, dOn;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        expInstRdata = 32'd0; expDataRdata = 32'd0;

        // Reset with both ports requesting: nothing may be accepted.
        rst = 1'b1;
        inst_req = 1'b1; data_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        checkOutput("reset_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        checkOutput("reset_inst_rdata", inst_rdata, 32'd0);
        checkOutput("reset_data_rdata", data_rdata, 32'd0);
        checkOutput("tieoff_len", 32'({arlen, awlen}), 32'd0);
        checkOutput("tieoff_burst", 32'({arburst, awburst}), 32'b0101);
        checkOutput("tieoff_misc", 32'({arlock, awlock, arcache, awcache, arprot, awprot, arid, awid, wid}), 32'd0);
        inst_req = 1'b0; data_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single inst read");
        ir = '{wr: 1'b0, size: 2'd2, addr: 32'hBFC0_0000, wdata: 32'd0, rdata: 32'h3C01_0000};
        dr = '0;
        applyStimulus(ir, 1, dr, 0, 0, 0, 0, 0, 0);

        $display("[TB] simultaneous reads, data port first");
        ir = '{wr: 1'b0, size: 2'd2, addr: 32'hBFC0_0004, wdata: 32'd0, rdata: 32'h2408_0001};
        dr = '{wr: 1'b0, size: 2'd2, addr: 32'h8000_1000, wdata: 32'd0, rdata: 32'hCAFE_F00D};
        applyStimulus(ir, 1, dr, 1, 0, 0, 0, 0, 0);
        applyStimulus(ir, 1, dr, 0, 1, 1, 0, 0, 0);

        $display("[TB] byte and half stores");
        dr = '{wr: 1'b1, size: 2'd0, addr: 32'h8000_0003, wdata: 32'hAA00_0000, rdata: 32'd0};
        applyStimulus(ir, 0, dr, 1, 0, 0, 0, 0, 0);
        dr = '{wr: 1'b1, size: 2'd1, addr: 32'h8000_0002, wdata: 32'h5566_0000, rdata: 32'd0};
        applyStimulus(ir, 0, dr, 1, 0, 0, 0, 0, 1);

        $display("[TB] write handshake ordering");
        dr = '{wr: 1'b1, size: 2'd2, addr: 32'h0000_1234, wdata: 32'h1234_5678, rdata: 32'd0};
        applyStimulus(ir, 0, dr, 1, 0, 0, 3, 0, 2);
        dr = '{wr: 1'b1, size: 2'd3, addr: 32'hA000_0010, wdata: 32'h8765_4321, rdata: 32'd0};
        applyStimulus(ir, 0, dr, 1, 0, 0, 2, 2, 0);

        $display("[TB] reset during read data phase");
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
        #1;
        checkOutput("mid_reset_grant", 32'(inst_addr_ok), 32'd1);
        @(posedge clk); #1;
        inst_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        #1;
        checkOutput("mid_reset_in_rdata", 32'(rready), 32'd1);
        rst = 1'b1; inst_req = 1'b1;
        #1;
        checkOutput("mid_reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        checkOutput("mid_reset_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        @(posedge clk); #1;
        inst_req = 1'b0; rst = 1'b0;
        expInstRdata = 32'd0; expDataRdata = 32'd0;
        #1;
        checkOutput("post_reset_inst_rdata", inst_rdata, 32'd0);
        ir = '{wr: 1'b0, size: 2'd2, addr: 32'hBFC0_0100, wdata: 32'd0, rdata: 32'h0BAD_F00D};
        applyStimulus(ir, 1, dr, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            ir  = randomReq();
            dr  = randomReq();
            iOn = 1'($urandom % 2);
            dOn = !iOn || 1'($urandom % 2);
            applyStimulus(ir, iOn, dr, dOn, int'($urandom % 4), int'($urandom % 4),
                          int'($urandom % 4), int'($urandom % 4), int'($urandom % 4));
            if (iOn && dOn) begin
                if (DATA_PRI)
                    applyStimulus(ir, 1, dr, 0, int'($urandom % 3), int'($urandom % 3),
                                  int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
                else
                    applyStimulus(ir, 0, dr, 1, int'($urandom % 3), int'($urandom % 3),
                                  int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
            end
            if (($urandom % 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
